// File: rtl/switch_4port_rtl_if.sv
// ---------------------------------------------------------------------------
// switch_4port_rtl_if
// Port bundle of the 4-port packet switch. Each signal is packed per port,
// index [p] selects port p (0..3).
//   ingress : valid_in_p, source_in_p, target_in_p, type_in_p, data_in_p
//   egress  : valid_out_p, source_out_p, target_out_p, type_out_p, data_out_p
//   status  : fifo_full_p, fifo_empty_p, fifo_count_p
//   optional: drop_cnt_p (only when DROP_CNT_EN is defined)
// Modports: master = traffic source / sink (bench side), slave = switch.
// ---------------------------------------------------------------------------
interface switch_4port_rtl_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
);
   logic [3:0]                    valid_in_p;
   logic [3:0][1:0]               source_in_p;
   logic [3:0][3:0]               target_in_p;
   logic [3:0][1:0]               type_in_p;
   logic [3:0][DATA_W-1:0]        data_in_p;

   logic [3:0]                    valid_out_p;
   logic [3:0][1:0]               source_out_p;
   logic [3:0][3:0]               target_out_p;
   logic [3:0][1:0]               type_out_p;
   logic [3:0][DATA_W-1:0]        data_out_p;

   logic [3:0]                    fifo_full_p;
   logic [3:0]                    fifo_empty_p;
   logic [3:0][CNT_W-1:0]         fifo_count_p;
`ifdef DROP_CNT_EN
   logic [3:0][15:0]              drop_cnt_p;
`endif

   modport master (
      output valid_in_p, source_in_p, target_in_p, type_in_p, data_in_p,
      input  valid_out_p, source_out_p, target_out_p, type_out_p, data_out_p,
      input  fifo_full_p, fifo_empty_p, fifo_count_p
`ifdef DROP_CNT_EN
      , input drop_cnt_p
`endif
   );

   modport slave (
      input  valid_in_p, source_in_p, target_in_p, type_in_p, data_in_p,
      output valid_out_p, source_out_p, target_out_p, type_out_p, data_out_p,
      output fifo_full_p, fifo_empty_p, fifo_count_p
`ifdef DROP_CNT_EN
      , output drop_cnt_p
`endif
   );
endinterface

// File: rtl/switch_4port_rtl.sv
// ---------------------------------------------------------------------------
// switch_4port_rtl
// 4-port packet switch. Each ingress port buffers packets {source, target,
// type, data} in its own FIFO_DEPTH-entry FIFO. A round-robin arbiter grants
// one non-empty FIFO per cycle and copies the head packet to every egress
// port whose bit is set in the packet's target mask (registered, one cycle).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - switch_4port_rtl_if.slave (ingress, egress, FIFO status)
// Optional feature: define DROP_CNT_EN to add per-port saturating 16-bit
// counters (bus.drop_cnt_p) that accumulate popcount(target_in) of every
// packet rejected because its FIFO was full.
// ---------------------------------------------------------------------------
module switch_4port_rtl #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   switch_4port_rtl_if.slave     bus
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [1:0]        src;
      logic [3:0]        tgt;
      logic [1:0]        typ;
      logic [DATA_W-1:0] data;
   } pkt_t;

   pkt_t             mem [4][FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr [4];
   logic [AW-1:0]    rd_ptr [4];
   logic [CNT_W-1:0] count  [4];

   pkt_t       pkt_in [4];
   logic [3:0] full, wr_en, rej, req, pop;
   logic [1:0] rr_ptr, gnt_idx, cand;
   logic       gnt_valid;
   pkt_t       head;

   // Ingress qualification. Full is taken from the current count, so a pop
   // on the same edge cannot make room for a write to a full FIFO.
   // NOTE: every always_comb output gets a default before any condition so no
   // latch is inferred; this block assigns all bits on every path.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pkt_in[i] = {bus.source_in_p[i], bus.target_in_p[i],
                      bus.type_in_p[i], bus.data_in_p[i]};
         full[i]   = (count[i] == CNT_W'(FIFO_DEPTH));
         wr_en[i]  = bus.valid_in_p[i] && !full[i] && (bus.target_in_p[i] != 4'b0);
         rej[i]    = bus.valid_in_p[i] && full[i];
         req[i]    = (count[i] != '0);
         bus.fifo_full_p[i]  = full[i];
         bus.fifo_empty_p[i] = !req[i];
         bus.fifo_count_p[i] = count[i];
      end
   end

   // Round-robin grant: first requester at or after rr_ptr, wrapping upward.
   // NOTE: combinational blocks use blocking (=) so later statements see the
   // updated value; clocked blocks use non-blocking (<=) to avoid races.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = rr_ptr;
      cand      = rr_ptr;
      for (int k = 0; k < 4; k++) begin
         cand = rr_ptr + 2'(k);
         if (!gnt_valid && req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++)
         pop[i] = gnt_valid && (gnt_idx == 2'(i));
   end

   assign head = mem[gnt_idx][rd_ptr[gnt_idx]];

   // NOTE: the packet storage has no reset; the pointers and counts that say
   // which entries are valid are reset, so stale contents are never read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (wr_en[i]) mem[i][wr_ptr[i]] <= pkt_in[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rr_ptr <= 2'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
            if (pop[i])   rd_ptr[i] <= rd_ptr[i] + AW'(1);
            case ({wr_en[i], pop[i]})
               2'b10:   count[i] <= count[i] + CNT_W'(1);
               2'b01:   count[i] <= count[i] - CNT_W'(1);
               default: count[i] <= count[i];
            endcase
         end
         if (gnt_valid) rr_ptr <= gnt_idx + 2'd1;
      end
   end

   // Egress registers: each targeted port gets one copy for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.valid_out_p  <= '0;
         bus.source_out_p <= '0;
         bus.target_out_p <= '0;
         bus.type_out_p   <= '0;
         bus.data_out_p   <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (gnt_valid && head.tgt[k]) begin
               bus.valid_out_p[k]  <= 1'b1;
               bus.source_out_p[k] <= head.src;
               bus.target_out_p[k] <= head.tgt;
               bus.type_out_p[k]   <= head.typ;
               bus.data_out_p[k]   <= head.data;
            end else begin
               bus.valid_out_p[k]  <= 1'b0;
               bus.source_out_p[k] <= '0;
               bus.target_out_p[k] <= '0;
               bus.type_out_p[k]   <= '0;
               bus.data_out_p[k]   <= '0;
            end
         end
      end
   end

`ifdef DROP_CNT_EN
   logic [15:0] drop_cnt [4];
   logic [16:0] drop_sum [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         drop_sum[i]       = {1'b0, drop_cnt[i]} + 17'($countones(bus.target_in_p[i]));
         bus.drop_cnt_p[i] = drop_cnt[i];
      end
   end

   // Saturating accumulate of lost copies per ingress port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) drop_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (rej[i]) drop_cnt[i] <= drop_sum[i][16] ? 16'hFFFF : drop_sum[i][15:0];
      end
   end
`endif
endmodule

// File: tb/tb_switch_4port_rtl.sv
module tb_switch_4port_rtl;
   typedef struct packed {
      logic [1:0] src;
      logic [3:0] tgt;
      logic [1:0] typ;
      logic [7:0] data;
   } pkt_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   switch_4port_rtl_if #(.DATA_W(8), .CNT_W(4)) bus ();

   switch_4port_rtl #(.DATA_W(8), .FIFO_DEPTH(8), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: one queue per ingress port, a round-robin turn index,
   // and the egress copies expected after the next edge.
   pkt_t       q [4][$];
   int         turn;
   logic [3:0] exp_valid;
   pkt_t       exp_pkt [4];
   int         drops [4];
   int         delivered;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.valid_in_p  = '0;
      bus.source_in_p = '0;
      bus.target_in_p = '0;
      bus.type_in_p   = '0;
      bus.data_in_p   = '0;
   endtask

   task automatic send(input int p, input logic [3:0] tgt, input logic [1:0] typ,
                       input logic [7:0] d);
      bus.valid_in_p[p]  = 1'b1;
      bus.source_in_p[p] = 2'(p);
      bus.target_in_p[p] = tgt;
      bus.type_in_p[p]   = typ;
      bus.data_in_p[p]   = d;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         drops[i]   = 0;
         exp_pkt[i] = '0;
      end
      turn      = 0;
      exp_valid = '0;
   endtask

   task automatic compare_all();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("valid_out[%0d]", k), 32'(bus.valid_out_p[k]), 32'(exp_valid[k]));
         if (exp_valid[k]) begin
            check($sformatf("source_out[%0d]", k), 32'(bus.source_out_p[k]), 32'(exp_pkt[k].src));
            check($sformatf("target_out[%0d]", k), 32'(bus.target_out_p[k]), 32'(exp_pkt[k].tgt));
            check($sformatf("type_out[%0d]", k),   32'(bus.type_out_p[k]),   32'(exp_pkt[k].typ));
            check($sformatf("data_out[%0d]", k),   32'(bus.data_out_p[k]),   32'(exp_pkt[k].data));
         end
         check($sformatf("count[%0d]", k), 32'(bus.fifo_count_p[k]), 32'(q[k].size()));
         check($sformatf("full[%0d]", k),  32'(bus.fifo_full_p[k]),  32'(q[k].size() == 8));
         check($sformatf("empty[%0d]", k), 32'(bus.fifo_empty_p[k]), 32'(q[k].size() == 0));
`ifdef DROP_CNT_EN
         check($sformatf("drop_cnt[%0d]", k), 32'(bus.drop_cnt_p[k]),
               32'((drops[k] > 65535) ? 65535 : drops[k]));
`endif
      end
   endtask

   // Advance one clock with the inputs currently driven; the model computes
   // the post-edge state, then the DUT is compared on the falling edge.
   task automatic step();
      int   g;
      logic accept [4];
      pkt_t p;
      g = -1;
      for (int k = 0; k < 4; k++)
         if (g < 0 && q[(turn + k) % 4].size() > 0) g = (turn + k) % 4;
      exp_valid = '0;
      for (int k = 0; k < 4; k++) exp_pkt[k] = '0;
      if (g >= 0) begin
         for (int k = 0; k < 4; k++)
            if (q[g][0].tgt[k]) begin
               exp_valid[k] = 1'b1;
               exp_pkt[k]   = q[g][0];
            end
      end
      for (int i = 0; i < 4; i++) begin
         accept[i] = 1'b0;
         if (bus.valid_in_p[i]) begin
            if (q[i].size() == 8) drops[i] += $countones(bus.target_in_p[i]);
            else if (bus.target_in_p[i] != 4'b0) accept[i] = 1'b1;
         end
      end
      if (g >= 0) begin
         void'(q[g].pop_front());
         turn = (g + 1) % 4;
      end
      for (int i = 0; i < 4; i++)
         if (accept[i]) begin
            p = {bus.source_in_p[i], bus.target_in_p[i], bus.type_in_p[i], bus.data_in_p[i]};
            q[i].push_back(p);
         end
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      compare_all();
      delivered += $countones(bus.valid_out_p);
   endtask

   // Asynchronous reset between edges; outputs must clear at once.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      idle_inputs();
      #1;
      model_clear();
      check("rst valid_out", 32'(bus.valid_out_p), 32'h0);
      check("rst data_out",  32'(bus.data_out_p),  32'h0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst count[%0d]", k), 32'(bus.fifo_count_p[k]), 32'h0);
         check($sformatf("rst empty[%0d]", k), 32'(bus.fifo_empty_p[k]), 32'h1);
         check($sformatf("rst full[%0d]", k),  32'(bus.fifo_full_p[k]),  32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && n < 200) begin
         step();
         n++;
      end
      check({tag, " drain bound"}, 32'(n < 200), 32'h1);
      check({tag, " all empty"}, 32'(bus.fifo_empty_p), 32'hF);
   endtask

   initial begin
      int   seen_full, max_cnt3, sent [4], sum_pop;
      logic [3:0] t;

      idle_inputs();
      model_clear();
      delivered = 0;
      repeat (2) @(negedge clk);
      async_reset();

      // Idle after reset.
      repeat (2) step();

      // Unicast 0 -> 2.
      send(0, 4'b0100, 2'd1, 8'hA5);
      step();
      check("uni count0 after write", 32'(bus.fifo_count_p[0]), 32'h1);
      check("uni no early output", 32'(bus.valid_out_p), 32'h0);
      step();
      check("uni valid_out", 32'(bus.valid_out_p), 32'b0100);
      check("uni data2", 32'(bus.data_out_p[2]), 32'hA5);
      check("uni source2", 32'(bus.source_out_p[2]), 32'h0);
      step();
      check("uni silent after", 32'(bus.valid_out_p), 32'h0);

      // Multicast from port 1 including itself.
      send(1, 4'b1011, 2'd2, 8'h3C);
      step();
      step();
      check("mc valid_out", 32'(bus.valid_out_p), 32'b1011);
      check("mc data0", 32'(bus.data_out_p[0]), 32'h3C);
      check("mc data1", 32'(bus.data_out_p[1]), 32'h3C);
      check("mc data3", 32'(bus.data_out_p[3]), 32'h3C);
      check("mc source3", 32'(bus.source_out_p[3]), 32'h1);

      // Zero target is discarded.
      send(2, 4'b0000, 2'd0, 8'h77);
      step();
      check("zero-tgt count2", 32'(bus.fifo_count_p[2]), 32'h0);
      step();
      check("zero-tgt silent", 32'(bus.valid_out_p), 32'h0);

      // Simultaneous arrivals after reset: grant order 0,1,2,3.
      @(negedge clk);
      async_reset();
      for (int p = 0; p < 4; p++) send(p, 4'b1111, 2'(p), 8'h10 + 8'(p));
      step();
      for (int n = 0; n < 4; n++) begin
         step();
         check($sformatf("order valid %0d", n), 32'(bus.valid_out_p), 32'hF);
         check($sformatf("order data %0d", n), 32'(bus.data_out_p[0]), 32'h10 + 32'(n));
         check($sformatf("order src %0d", n), 32'(bus.source_out_p[3]), 32'(n));
      end
      step();
      check("order done", 32'(bus.valid_out_p), 32'h0);

      // Overload: every port sends each cycle; port 3 fills and drops.
      seen_full = 0;
      max_cnt3  = 0;
      for (int c = 0; c < 16; c++) begin
         for (int p = 0; p < 3; p++) send(p, 4'b0001, 2'd0, 8'(c));
         send(3, 4'b1110, 2'd3, 8'h80 + 8'(c));
         step();
         if (bus.fifo_full_p[3]) seen_full = 1;
         if (int'(bus.fifo_count_p[3]) > max_cnt3) max_cnt3 = int'(bus.fifo_count_p[3]);
      end
      check("ovl port3 reached full", 32'(seen_full), 32'h1);
      check("ovl port3 max count", 32'(max_cnt3), 32'h8);

      // Reset in the middle of traffic flushes everything.
      for (int p = 0; p < 4; p++) send(p, 4'b1111, 2'd0, 8'hEE);
      async_reset();
      step();

      // Random traffic: 20 packets per port, conservation of copies.
      delivered = 0;
      sum_pop   = 0;
      for (int p = 0; p < 4; p++) sent[p] = 0;
      for (int c = 0; c < 400 && (sent[0] + sent[1] + sent[2] + sent[3]) < 80; c++) begin
         for (int p = 0; p < 4; p++)
            if (sent[p] < 20 && $urandom_range(0, 3) != 0) begin
               t = 4'($urandom_range(0, 15));
               send(p, t, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
               sum_pop += $countones(t);
               sent[p]++;
            end
         step();
      end
      check("rnd all sent", 32'(sent[0] + sent[1] + sent[2] + sent[3]), 32'd80);
      drain("rnd");
      step();
      check("rnd conservation", 32'(delivered + drops[0] + drops[1] + drops[2] + drops[3]),
            32'(sum_pop));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/switch_4port_rtl.md
Name: switch_4port_rtl

Overview:
- 4-port packet switch; each port has an ingress side (packet in) and an egress side (packet out).
- Every ingress packet carries a 4-bit target mask and is buffered in a per-port 8-entry FIFO.
- A round-robin arbiter picks one non-empty FIFO per cycle and copies its head packet to every egress port named in the mask (unicast or multicast).
- Top-level datapath block under the switch testbench; the four port_if bundles are flattened into per-port signals.

Parameters:
- DATA_W, 8, payload width
- FIFO_DEPTH, 8, entries per ingress FIFO (power of two)
- CNT_W, 4, FIFO occupancy counter width, must hold 0..FIFO_DEPTH

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- valid_in_p[0..3]  in  1 each  ingress packet strobe, one packet per cycle
- source_in_p[0..3]  in  2 each  originating port id
- target_in_p[0..3]  in  4 each  egress mask, bit k = deliver to port k
- type_in_p[0..3]  in  2 each  packet type, opaque
- data_in_p[0..3]  in  DATA_W each  payload
- valid_out_p[0..3]  out  1 each  egress packet strobe
- source_out_p[0..3]  out  2 each  forwarded source id
- target_out_p[0..3]  out  4 each  forwarded original mask
- type_out_p[0..3]  out  2 each  forwarded type
- data_out_p[0..3]  out  DATA_W each  forwarded payload
- fifo_full_p[0..3]  out  1 each  ingress FIFO full
- fifo_empty_p[0..3]  out  1 each  ingress FIFO empty
- fifo_count_p[0..3]  out  CNT_W each  ingress FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - all FIFOs empty, count 0, full 0, empty 1
  - all valid_out 0, all out fields 0
  - arbiter pointer = port 0
- Ingress:
  - On a clk edge with valid_in=1, full=0 and target!=0, the packet {source, target, type, data} is written.
  - valid_in while full: packet dropped silently; no other state changes.
  - target==0: packet discarded and not written.
- FIFO:
  - synchronous write and read, pointers wrap modulo FIFO_DEPTH
  - full = (count==FIFO_DEPTH), empty = (count==0)
  - Simultaneous write+pop on a full FIFO: the write is rejected, because full is evaluated before the pop.
  - Simultaneous write+pop on a non-full FIFO: count unchanged.
- Arbiter:
  - request[i] = !empty[i]
  - Grant is combinational: the first requester at or after the pointer, searching upward with wrap.
  - The granted FIFO pops on the same edge; the pointer then moves to granted+1 mod 4.
  - No requests: no grant, pointer holds.
  - At most one grant per cycle.
- Egress:
  - On a grant edge, every port k whose bit target[k] is set in the head packet loads valid_out_p[k]=1 and the packet fields.
  - All other egress ports load valid_out=0.
  - Outputs are registered and held for exactly one cycle per packet; there is no backpressure.
  - Self-target (source port == target bit) is legal.
- Latency: a packet written at edge E into an empty FIFO with no competing requests appears on its egress ports after edge E+1.
- Throughput: one packet per cycle switch-wide, so sustained input on all four ports eventually fills the FIFOs and drops packets.
- Integrity: every accepted packet is delivered exactly once to every target in its mask. Losses happen only at ingress full.

Optional Feature:
- Macro DROP_CNT_EN.
- Defined:
  - adds outputs drop_cnt_p[0..3], 16 bits each, reset 0
  - On each rejected ingress (valid_in while full), add popcount(target_in) to that port's counter.
  - Counters saturate at 16'hFFFF.
- Undefined: the outputs and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: all valid_out=0, fifo_count=0, fifo_empty=1 on all ports; assert rst_n=0 mid-traffic → FIFOs flush and outputs clear immediately.
- Port 0 sends one packet, target=4'b0100, data=8'hA5 → valid_out_p[2]=1 after edge E+1 with data 8'hA5 and source 0; all other ports stay silent.
- Port 1 sends multicast target=4'b1011 → ports 0, 1 and 3 each see one copy in the same cycle.
- All four ports send one packet in the same cycle after reset → outputs appear in grant order 0, 1, 2, 3 on consecutive cycles.
- Port 3 is driven continuously while its target port is idle, with ports 0–2 also busy → port 3's count reaches 8, full=1, further inputs are dropped. With DROP_CNT_EN, drop_cnt_p[3] increases by popcount(target) per dropped packet.
- Random traffic, 20 packets per port → delivered copies + drop count == sum of popcount(target) over all sent packets; all FIFOs drain to empty.
